// File: rtl/counter_step_driver_if.sv
// rtl/counter_step_driver_if.sv - control-side and counter-side signals of the step driver
// master: controller plus counter; slave: the driver itself.
interface counter_step_driver_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] target;
  logic             abort;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] cnt_in;
  logic             enable;
  logic             up_down;

  modport master (
    output start, target, abort, cnt_in,
    input  busy, done, err, enable, up_down
  );

  modport slave (
    input  start, target, abort, cnt_in,
    output busy, done, err, enable, up_down
  );
endinterface

// File: rtl/counter_step_driver.sv
// rtl/counter_step_driver.sv - steps an up/down counter to a target along the shortest wrap path
// Step count is fixed at start; cnt_in is only consulted again when checking the result.
module counter_step_driver #(
  parameter int WIDTH    = 8,
  parameter int STEP_GAP = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  counter_step_driver_if.slave  bus
);

  localparam int GW = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] remaining_q;
  logic [GW-1:0]    gap_q;
  logic             enable_q;
  logic             up_down_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [WIDTH-1:0] up_dist_d;
  logic [WIDTH-1:0] dn_dist_d;
  logic [WIDTH-1:0] steps_d;
  logic [WIDTH-1:0] remaining_d;
  logic             dir_d;

  // Modular distances both ways; a tie resolves upward.
  always_comb begin
    up_dist_d   = bus.target - bus.cnt_in;
    dn_dist_d   = bus.cnt_in - bus.target;
    dir_d       = (up_dist_d <= dn_dist_d);
    steps_d     = dir_d ? up_dist_d : dn_dist_d;
    remaining_d = remaining_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      remaining_q <= '0;
      gap_q       <= '0;
      enable_q    <= 1'b0;
      up_down_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            target_q    <= bus.target;
            up_down_q   <= dir_d;
            remaining_q <= steps_d;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            if (steps_d == '0) begin
              state_q  <= S_SETTLE;
              enable_q <= 1'b0;
            end else begin
              state_q  <= S_RUN;
              enable_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          remaining_q <= remaining_d;
          if (bus.abort || remaining_d == '0) begin
            state_q  <= S_SETTLE;
            enable_q <= 1'b0;
          end else if (STEP_GAP > 0) begin
            state_q  <= S_GAP;
            enable_q <= 1'b0;
            gap_q    <= GW'(STEP_GAP - 1);
          end else begin
            enable_q <= 1'b1;
          end
        end
        S_GAP: begin
          if (bus.abort) begin
            state_q <= S_SETTLE;
          end else if (gap_q == '0) begin
            state_q  <= S_RUN;
            enable_q <= 1'b1;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        S_SETTLE: begin
          err_q   <= (bus.cnt_in != target_q);
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          enable_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.enable  = enable_q;
  assign bus.up_down = up_down_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_counter_step_driver.sv
// tb/tb_counter_step_driver.sv - bench for counter_step_driver (STEP_GAP 0 and 2 instances)
module tb_counter_step_driver;

  typedef struct packed {
    bit en;
    bit busy;
    bit done;
    bit err;
  } ent_t;

  logic clk;
  logic rst_n;

  logic       start_r [2];
  logic [7:0] tgt_r   [2];
  logic       abort_r [2];
  logic       load_r  [2];
  logic [7:0] ldv_r   [2];
  logic [7:0] cnt     [2];
  logic       en_w    [2];
  logic       ud_w    [2];
  logic       busy_w  [2];
  logic       done_w  [2];
  logic       err_w   [2];

  int abort_plan [2];
  int clr_plan   [2];
  bit mdir       [2];
  bit merr       [2];
  bit cur_idle   [2];
  ent_t q0[$];
  ent_t q1[$];

  int n_tests = 0;
  int n_fail  = 0;

  counter_step_driver_if #(.WIDTH(8)) if0 ();
  counter_step_driver_if #(.WIDTH(8)) if1 ();

  counter_step_driver #(.WIDTH(8), .STEP_GAP(0)) dut0 (.clk(clk), .reset(rst_n), .bus(if0));
  counter_step_driver #(.WIDTH(8), .STEP_GAP(2)) dut1 (.clk(clk), .reset(rst_n), .bus(if1));

  assign if0.start  = start_r[0];
  assign if0.target = tgt_r[0];
  assign if0.abort  = abort_r[0];
  assign if0.cnt_in = cnt[0];
  assign if1.start  = start_r[1];
  assign if1.target = tgt_r[1];
  assign if1.abort  = abort_r[1];
  assign if1.cnt_in = cnt[1];
  assign en_w[0] = if0.enable;
  assign ud_w[0] = if0.up_down;
  assign busy_w[0] = if0.busy;
  assign done_w[0] = if0.done;
  assign err_w[0] = if0.err;
  assign en_w[1] = if1.enable;
  assign ud_w[1] = if1.up_down;
  assign busy_w[1] = if1.busy;
  assign done_w[1] = if1.done;
  assign err_w[1] = if1.err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The counter being driven: 8-bit up/down with a load port for stimulus
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (load_r[d]) cnt[d] <= ldv_r[d];
      else if (en_w[d]) cnt[d] <= ud_w[d] ? cnt[d] + 8'd1 : cnt[d] - 8'd1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic push_ent(input int d, input ent_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Expected per-cycle schedule of one move, derived from distance and gap rules
  task automatic build(input int d);
    logic [7:0] c, t, up, dn, fin;
    int n, p;
    bit dir;
    c   = cnt[d];
    t   = tgt_r[d];
    up  = t - c;
    dn  = c - t;
    dir = (up <= dn);
    n   = dir ? int'(up) : int'(dn);
    p   = (abort_plan[d] > 0 && abort_plan[d] < n) ? abort_plan[d] : n;
    if (clr_plan[d] > 0 && clr_plan[d] <= p)
      fin = dir ? 8'(p - clr_plan[d]) : 8'(clr_plan[d] - p);
    else
      fin = dir ? 8'(int'(c) + p) : 8'(int'(c) - p);
    for (int i = 1; i <= p; i++) begin
      push_ent(d, '{1'b1, 1'b1, 1'b0, 1'b0});
      if (i < p) repeat (gap_of(d)) push_ent(d, '{1'b0, 1'b1, 1'b0, 1'b0});
    end
    push_ent(d, '{1'b0, 1'b1, 1'b0, 1'b0});
    push_ent(d, '{1'b0, 1'b1, 1'b1, fin != t});
    mdir[d] = dir;
  endtask

  // Compare process: every falling edge, both instances
  initial begin
    ent_t e;
    int   sz;
    for (int d = 0; d < 2; d++) begin
      cur_idle[d] = 1'b1;
      mdir[d] = 1'b0;
      merr[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        sz = (d == 0) ? q0.size() : q1.size();
        if (!rst_n) begin
          if (d == 0) q0.delete(); else q1.delete();
          mdir[d] = 1'b0;
          merr[d] = 1'b0;
          cur_idle[d] = 1'b1;
          e = '{1'b0, 1'b0, 1'b0, 1'b0};
        end else if (sz > 0) begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          cur_idle[d] = 1'b0;
          if (e.done) merr[d] = e.err;
        end else begin
          cur_idle[d] = 1'b1;
          e = '{1'b0, 1'b0, 1'b0, merr[d]};
        end
        chk((d == 0) ? "cycle_dut0_en_ud_busy_done_err" : "cycle_dut1_en_ud_busy_done_err",
            int'({en_w[d], ud_w[d], busy_w[d], done_w[d], err_w[d]}),
            int'({e.en, mdir[d], e.busy, e.done, e.err}));
      end
    end
  end

  // Model acceptance: a start is taken only when the current cycle is idle
  initial begin
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++)
        if (rst_n && cur_idle[d] && start_r[d]) build(d);
    end
  end

  task automatic load_cnt(input int d, input logic [7:0] v);
    @(negedge clk);
    load_r[d] = 1'b1;
    ldv_r[d]  = v;
    @(negedge clk);
    load_r[d] = 1'b0;
  endtask

  task automatic do_move(input int d, input logic [7:0] tgt, input int ab, input int clr,
                         input bit st2, output int pulses, output int lat, output bit e);
    @(negedge clk);
    abort_plan[d] = ab;
    clr_plan[d]   = clr;
    tgt_r[d]      = tgt;
    start_r[d]    = 1'b1;
    pulses = 0;
    lat    = 0;
    e      = 1'b0;
    for (int c = 1; c <= 4000; c++) begin
      @(negedge clk);
      start_r[d] = 1'b0;
      abort_r[d] = 1'b0;
      load_r[d]  = 1'b0;
      if (en_w[d]) begin
        pulses++;
        if (pulses == ab) abort_r[d] = 1'b1;
        if (pulses == clr) begin
          load_r[d] = 1'b1;
          ldv_r[d]  = 8'd0;
        end
        if (st2 && pulses == 2) start_r[d] = 1'b1;
      end
      if (done_w[d]) begin
        lat = c;
        e   = err_w[d];
        break;
      end
    end
    if (lat == 0) chk("move_timeout", 0, 1);
    abort_plan[d] = 0;
    clr_plan[d]   = 0;
  endtask

  initial begin
    int p, l, ab, c0, t0;
    bit e;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_r[d] = 1'b0;
      tgt_r[d]   = 8'd0;
      abort_r[d] = 1'b0;
      load_r[d]  = 1'b0;
      ldv_r[d]   = 8'd0;
      cnt[d]     = 8'd0;
      abort_plan[d] = 0;
      clr_plan[d]   = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", int'(busy_w[0]), 0);
    chk("reset_ud", int'(ud_w[0]), 0);

    load_cnt(0, 8'd10);
    do_move(0, 8'd13, 0, 0, 1'b0, p, l, e);
    chk("up_pulses", p, 3);
    chk("up_latency", l, 5);
    chk("up_err", int'(e), 0);
    chk("up_dir", int'(ud_w[0]), 1);
    chk("up_count", int'(cnt[0]), 13);

    load_cnt(0, 8'd2);
    do_move(0, 8'd250, 0, 0, 1'b0, p, l, e);
    chk("wrap_pulses", p, 8);
    chk("wrap_latency", l, 10);
    chk("wrap_err", int'(e), 0);
    chk("wrap_dir", int'(ud_w[0]), 0);
    chk("wrap_count", int'(cnt[0]), 250);

    load_cnt(0, 8'd77);
    do_move(0, 8'd77, 0, 0, 1'b0, p, l, e);
    chk("zero_pulses", p, 0);
    chk("zero_latency", l, 2);
    chk("zero_err", int'(e), 0);

    load_cnt(0, 8'd0);
    do_move(0, 8'd20, 5, 0, 1'b0, p, l, e);
    chk("abort_pulses", p, 5);
    chk("abort_latency", l, 7);
    chk("abort_err", int'(e), 1);
    chk("abort_count", int'(cnt[0]), 5);

    load_cnt(0, 8'd10);
    do_move(0, 8'd13, 0, 0, 1'b1, p, l, e);
    chk("restart_pulses", p, 3);
    chk("restart_latency", l, 5);

    load_cnt(0, 8'd0);
    do_move(0, 8'd20, 0, 10, 1'b0, p, l, e);
    chk("extclr_pulses", p, 20);
    chk("extclr_err", int'(e), 1);

    load_cnt(1, 8'd0);
    do_move(1, 8'd128, 0, 0, 1'b0, p, l, e);
    chk("gap_pulses", p, 128);
    chk("gap_latency", l, 384);
    chk("gap_err", int'(e), 0);
    chk("gap_dir", int'(ud_w[1]), 1);

    for (int i = 0; i < 30; i++) begin
      c0 = $urandom_range(0, 255);
      t0 = $urandom_range(0, 255);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
      load_cnt(0, 8'(c0));
      do_move(0, 8'(t0), ab, 0, 1'b0, p, l, e);
    end
    for (int i = 0; i < 8; i++) begin
      c0 = $urandom_range(0, 255);
      t0 = c0 + $urandom_range(0, 40) - 20;
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 10) : 0;
      load_cnt(1, 8'(c0));
      do_move(1, 8'(t0), ab, 0, 1'b0, p, l, e);
    end

    // Asynchronous reset while pulsing
    load_cnt(0, 8'd0);
    @(negedge clk);
    tgt_r[0]   = 8'd100;
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pre_enable", int'(en_w[0]), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_enable", int'(en_w[0]), 0);
    chk("rst_async_busy", int'(busy_w[0]), 0);
    chk("rst_async_done", int'(done_w[0]), 0);
    chk("rst_async_err", int'(err_w[0]), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_post_busy", int'(busy_w[0]), 0);
    chk("rst_post_enable", int'(en_w[0]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_step_driver.md
Name: counter_step_driver

Overview:
- Command-side master for the 8-bit up/down counter interface (enable, up_down, 8-bit count).
- On a start request, reads the counter's current value and computes the shortest wrap-around path to a target.
- Issues exactly that many enable pulses with the chosen direction, then checks the counter's value against the target.
- Sits between control logic and the counter, and owns the counter's enable and up_down inputs.

Parameters:
WIDTH, 8, counter width in bits; also the width of target, cnt_in and the step counter.
STEP_GAP, 0, idle cycles inserted between consecutive enable pulses (0 = enable held continuously).

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
start  input  1  request; sampled only in IDLE.
target  input  WIDTH  destination count; captured on an accepted start.
abort  input  1  cancels a move in progress.
cnt_in  input  WIDTH  counter output fed back.
enable  output  1  to the counter's enable.
up_down  output  1  to the counter's up_down (1 = up).
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse when a move completes.
err  output  1  mismatch flag; sticky until the next accepted start.

Behaviour:
- Reset (reset=0, async): state=IDLE; enable=0, up_down=0, busy=0, done=0, err=0; step counter and gap counter cleared. All outputs are registered.
- Reset mid-move drops enable immediately and asynchronously. No done pulse is issued.
- States: IDLE, RUN, GAP, SETTLE, DONE.
- IDLE, start=1 at edge k:
  - Capture target.
  - up_dist = (target - cnt_in) mod 2^WIDTH; dn_dist = (cnt_in - target) mod 2^WIDTH.
  - If up_dist <= dn_dist, direction is up with steps=up_dist; otherwise down with steps=dn_dist. A tie goes up.
  - Clear err. If steps=0, go to SETTLE with enable=0; otherwise go to RUN.
- RUN: enable=1 for exactly one cycle per step, up_down=direction. The first enable is seen in cycle k+1.
  - Each RUN edge decrements remaining.
  - If the decremented remaining = 0, go to SETTLE.
  - Else if STEP_GAP>0, go to GAP; else stay in RUN, so enable stays continuously high.
- GAP: enable=0 for STEP_GAP cycles, then return to RUN.
- SETTLE: enable=0 for one cycle, so cnt_in reflects the last step. At the edge leaving SETTLE: err <= (cnt_in != captured target); go to DONE.
- DONE: done=1 for exactly one cycle, busy=1; then IDLE.
- up_down holds its value through GAP, SETTLE, DONE and IDLE. It changes only on an accepted start.
- Timing for N steps with STEP_GAP=0:
  - enable is high in cycles k+1..k+N.
  - SETTLE is cycle k+N+1; done is cycle k+N+2.
  - Total latency is N+2 cycles after the start edge, and N+2 cycles for N=0 as well (SETTLE k+1, done k+2).
- Timing with STEP_GAP=G: the enable pulses are separated by G low cycles.
- Maximum step count is 2^(WIDTH-1), reached when target = cnt_in + 128 for WIDTH=8 (tie goes up).
- Wrap-around is intrinsic: 250 -> 4 is 10 up-steps through 255 -> 0.
- abort=1 in RUN or GAP:
  - enable=0 from the next cycle; no further pulses.
  - Go to SETTLE, then DONE, so the mismatch check runs normally (err=1 unless the target was already reached).
- abort is ignored in IDLE, SETTLE and DONE.
- start while busy is ignored (not queued). start and abort together in IDLE: start is accepted and abort is ignored.
- The driver never uses cnt_in during RUN/GAP; the step count is fixed at start.
- An external change of the count during a move (e.g. the counter's own reset) shows up only as err.

Test Plan:
- Reset: assert reset=0 during RUN with enable=1 -> enable, busy, done and err go to 0 immediately, without waiting for a clock edge; state is IDLE after release.
- Up move: cnt_in=10, start with target=13, STEP_GAP=0 -> enable high in exactly 3 consecutive cycles with up_down=1; counter reads 13; done pulses at k+5; err=0.
- Wrap down: cnt_in=2, target=250 -> 8 down pulses (2 -> 1 -> 0 -> 255 ... 250), up_down=0; done at k+10; err=0.
- Tie and gap: STEP_GAP=2, cnt_in=0, target=128 -> 128 up pulses, each followed by 2 low cycles except the last; done at k+1+128+127*2+1; err=0.
- Zero and abort:
  - target equal to cnt_in=77 -> no enable pulses, done at k+2, err=0.
  - Separately, 0 -> 20 with abort at the 5th pulse -> no pulses after the 5th, done two cycles later, err=1.
- Collisions: a second start during RUN is ignored (busy stays 1, pulse count unchanged); counter externally reset mid-move -> err=1 at done.
